// File: rtl/axi_mem_slave.sv
// AXI4 memory responder: single-initiator, one outstanding read and one outstanding write,
// INCR bursts of full-width beats into a word-indexed backing store.
module axi_mem_slave #(
   parameter int ADDR_WIDTH = 48,
   parameter int DATA_WIDTH = 128,
   parameter int MEM_WORDS  = 1024
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
   input  logic [7:0]                s_axi_arlen,
   input  logic [2:0]                s_axi_arsize,
   input  logic [1:0]                s_axi_arburst,
   input  logic                      s_axi_arvalid,
   output logic                      s_axi_arready,
   output logic [DATA_WIDTH-1:0]     s_axi_rdata,
   output logic [1:0]                s_axi_rresp,
   output logic                      s_axi_rlast,
   output logic                      s_axi_rvalid,
   input  logic                      s_axi_rready,
   input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
   input  logic [7:0]                s_axi_awlen,
   input  logic [2:0]                s_axi_awsize,
   input  logic [1:0]                s_axi_awburst,
   input  logic                      s_axi_awvalid,
   output logic                      s_axi_awready,
   input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
   input  logic                      s_axi_wlast,
   input  logic                      s_axi_wvalid,
   output logic                      s_axi_wready,
   output logic [1:0]                s_axi_bresp,
   output logic                      s_axi_bvalid,
   input  logic                      s_axi_bready
);
   localparam int         STRB_W  = DATA_WIDTH / 8;
   localparam int         BSH     = $clog2(STRB_W);
   localparam int         IDX_W   = $clog2(MEM_WORDS);
   localparam logic [2:0] SIZE_OK = 3'(BSH);
   localparam logic [1:0] OKAY    = 2'b00;
   localparam logic [1:0] SLVERR  = 2'b10;

   typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;
   typedef enum logic [1:0] {W_IDLE = 2'b00, W_DATA = 2'b01, W_RESP = 2'b10} w_state_t;

   logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

   r_state_t              r_rstate, w_rnext;
   w_state_t              r_wstate, w_wnext;
   logic [IDX_W-1:0]      r_ridx, r_widx;
   logic [7:0]            r_arlen, r_rcnt, r_awlen, r_wcnt;
   logic                  r_rerr, r_wburst_err, r_wproto_err;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [1:0]            r_rresp, r_bresp;
   logic                  r_rlast;

   logic                  w_ar_hs, w_r_hs, w_r_done, w_ar_err;
   logic                  w_aw_hs, w_w_hs, w_w_final, w_b_hs, w_aw_err, w_wlast_bad;
   logic [IDX_W-1:0]      w_ar_idx, w_aw_idx, w_ridx_nxt;
   logic [DATA_WIDTH-1:0] w_wmerged;
   logic                  w_unused_addr;

   assign w_unused_addr = ^{s_axi_araddr, s_axi_awaddr};

   assign s_axi_arready = (r_rstate == R_IDLE);
   assign s_axi_rvalid  = (r_rstate == R_DATA);
   assign s_axi_rdata   = r_rdata;
   assign s_axi_rresp   = r_rresp;
   assign s_axi_rlast   = r_rlast;
   assign s_axi_awready = (r_wstate == W_IDLE);
   assign s_axi_wready  = (r_wstate == W_DATA);
   assign s_axi_bvalid  = (r_wstate == W_RESP);
   assign s_axi_bresp   = r_bresp;

   assign w_ar_hs    = s_axi_arvalid && (r_rstate == R_IDLE);
   assign w_r_hs     = s_axi_rready && (r_rstate == R_DATA);
   assign w_r_done   = w_r_hs && (r_rcnt == r_arlen);
   assign w_ar_err   = (s_axi_arburst != 2'b01) || (s_axi_arsize != SIZE_OK);
   assign w_ar_idx   = s_axi_araddr[BSH +: IDX_W];
   assign w_ridx_nxt = r_ridx + IDX_W'(1);

   assign w_aw_hs     = s_axi_awvalid && (r_wstate == W_IDLE);
   assign w_w_hs      = s_axi_wvalid && (r_wstate == W_DATA);
   assign w_w_final   = w_w_hs && (r_wcnt == r_awlen);
   assign w_b_hs      = s_axi_bready && (r_wstate == W_RESP);
   assign w_aw_err    = (s_axi_awburst != 2'b01) || (s_axi_awsize != SIZE_OK);
   assign w_aw_idx    = s_axi_awaddr[BSH +: IDX_W];
   assign w_wlast_bad = s_axi_wlast != (r_wcnt == r_awlen);

   // FSM state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rstate <= R_IDLE;
         r_wstate <= W_IDLE;
      end else begin
         r_rstate <= w_rnext;
         r_wstate <= w_wnext;
      end
   end

   // Read next-state
   always_comb begin
      w_rnext = r_rstate;
      case (r_rstate)
         R_IDLE:  w_rnext = w_ar_hs  ? R_DATA : R_IDLE;
         R_DATA:  w_rnext = w_r_done ? R_IDLE : R_DATA;
         default: w_rnext = R_IDLE;
      endcase
   end

   // Write next-state
   always_comb begin
      w_wnext = r_wstate;
      case (r_wstate)
         W_IDLE:  w_wnext = w_aw_hs   ? W_DATA : W_IDLE;
         W_DATA:  w_wnext = w_w_final ? W_RESP : W_DATA;
         W_RESP:  w_wnext = w_b_hs    ? W_IDLE : W_RESP;
         default: w_wnext = W_IDLE;
      endcase
   end

   // Read datapath: rdata is preloaded on AR and on every non-final R handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ridx  <= '0;
         r_arlen <= 8'd0;
         r_rcnt  <= 8'd0;
         r_rerr  <= 1'b0;
         r_rdata <= '0;
         r_rresp <= OKAY;
         r_rlast <= 1'b0;
      end else if (w_ar_hs) begin
         r_ridx  <= w_ar_idx;
         r_arlen <= s_axi_arlen;
         r_rcnt  <= 8'd0;
         r_rerr  <= w_ar_err;
         r_rdata <= w_ar_err ? '0 : r_mem[w_ar_idx];
         r_rresp <= w_ar_err ? SLVERR : OKAY;
         r_rlast <= (s_axi_arlen == 8'd0);
      end else if (w_r_done) begin
         r_rlast <= 1'b0;
      end else if (w_r_hs) begin
         r_ridx  <= w_ridx_nxt;
         r_rcnt  <= r_rcnt + 8'd1;
         r_rdata <= r_rerr ? '0 : r_mem[w_ridx_nxt];
         r_rlast <= ((r_rcnt + 8'd1) == r_arlen);
      end
   end

   // Write datapath and response status
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_widx       <= '0;
         r_awlen      <= 8'd0;
         r_wcnt       <= 8'd0;
         r_wburst_err <= 1'b0;
         r_wproto_err <= 1'b0;
         r_bresp      <= OKAY;
      end else if (w_aw_hs) begin
         r_widx       <= w_aw_idx;
         r_awlen      <= s_axi_awlen;
         r_wcnt       <= 8'd0;
         r_wburst_err <= w_aw_err;
         r_wproto_err <= 1'b0;
      end else if (w_w_hs) begin
         r_widx       <= r_widx + IDX_W'(1);
         r_wcnt       <= r_wcnt + 8'd1;
         r_wproto_err <= r_wproto_err | w_wlast_bad;
         if (w_w_final) begin
            r_bresp <= (r_wburst_err || r_wproto_err || w_wlast_bad) ? SLVERR : OKAY;
         end
      end
   end

   // Byte-lane merge of the incoming beat over the stored word
   always_comb begin
      w_wmerged = r_mem[r_widx];
      for (int b = 0; b < STRB_W; b++) begin
         if (s_axi_wstrb[b]) begin
            w_wmerged[8*b +: 8] = s_axi_wdata[8*b +: 8];
         end else begin
            w_wmerged[8*b +: 8] = r_mem[r_widx][8*b +: 8];
         end
      end
   end

   // Backing store: deliberately not reset; burst-error writes are dropped
   always_ff @(posedge clk) begin
      if (w_w_hs && !r_wburst_err) begin
         r_mem[r_widx] <= w_wmerged;
      end
   end
endmodule

// File: tb/tb_axi_mem_slave.sv
// Self-checking bench for axi_mem_slave: directed scenarios plus randomized bursts,
// checked against a word-array model of the memory.
module tb_axi_mem_slave;
   localparam int AW = 48;
   localparam int DW = 128;
   localparam int SW = DW / 8;
   localparam int MW = 1024;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] s_axi_araddr, s_axi_awaddr;
   logic [7:0]    s_axi_arlen, s_axi_awlen;
   logic [2:0]    s_axi_arsize, s_axi_awsize;
   logic [1:0]    s_axi_arburst, s_axi_awburst;
   logic          s_axi_arvalid, s_axi_arready;
   logic [DW-1:0] s_axi_rdata;
   logic [1:0]    s_axi_rresp;
   logic          s_axi_rlast, s_axi_rvalid, s_axi_rready;
   logic          s_axi_awvalid, s_axi_awready;
   logic [DW-1:0] s_axi_wdata;
   logic [SW-1:0] s_axi_wstrb;
   logic          s_axi_wlast, s_axi_wvalid, s_axi_wready;
   logic [1:0]    s_axi_bresp;
   logic          s_axi_bvalid, s_axi_bready;

   int            n_vec = 0;
   int            n_err = 0;
   logic [DW-1:0] mdl [MW];

   axi_mem_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_WORDS(MW)) dut (
      .clk(clk), .rst(rst),
      .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
      .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
      .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
      .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
      .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
      .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic axi_write(input logic [AW-1:0] addr, input int len, input logic [2:0] size,
                            input logic [1:0] burst, input int dmode, input logic [DW-1:0] dval,
                            input logic [SW-1:0] strb, input bit rnd_strb, input int wlast_pos);
      int            idx, cyc;
      bit            err, bad;
      logic          rdy;
      logic [DW-1:0] d;
      logic [SW-1:0] s;
      err = (burst != 2'b01) || (size != 3'd4);
      idx = int'((addr >> 4) % MW);
      bad = 1'b0;
      s_axi_awaddr = addr; s_axi_awlen = 8'(len); s_axi_awsize = size; s_axi_awburst = burst;
      s_axi_awvalid = 1'b1;
      cyc = 0;
      do begin rdy = s_axi_awready; tick(); cyc++; end while (!rdy && cyc < 50);
      chk("aw_handshake", rdy, 1'b1);
      s_axi_awvalid = 1'b0;
      for (int i = 0; i <= len; i++) begin
         d = (dmode == 0) ? DW'(i) : (dmode == 1) ? {$urandom, $urandom, $urandom, $urandom} : dval;
         s = rnd_strb ? SW'($urandom) : strb;
         if ($urandom_range(0, 3) == 0) begin s_axi_wvalid = 1'b0; tick(); end
         s_axi_wdata = d; s_axi_wstrb = s; s_axi_wlast = (i == wlast_pos); s_axi_wvalid = 1'b1;
         if ((i == len) != (i == wlast_pos)) bad = 1'b1;
         cyc = 0;
         do begin rdy = s_axi_wready; tick(); cyc++; end while (!rdy && cyc < 50);
         chk("w_beat_accept", rdy, 1'b1);
         if (!err) begin
            for (int b = 0; b < SW; b++) if (s[b]) mdl[(idx + i) % MW][8*b +: 8] = d[8*b +: 8];
         end
      end
      s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_bready = 1'b0;
      chk("wready_in_resp", s_axi_wready, 1'b0);
      repeat ($urandom_range(0, 2)) begin
         chk("bvalid_hold", s_axi_bvalid, 1'b1);
         tick();
      end
      chk("bvalid", s_axi_bvalid, 1'b1);
      chk("bresp", s_axi_bresp, (err || bad) ? 2'b10 : 2'b00);
      s_axi_bready = 1'b1; tick(); s_axi_bready = 1'b0;
      chk("bvalid_clear", s_axi_bvalid, 1'b0);
      chk("awready_idle", s_axi_awready, 1'b1);
   endtask

   // rmode: 0 rready always high, 1 toggling, 2 random
   task automatic axi_read(input logic [AW-1:0] addr, input int len, input logic [2:0] size,
                           input logic [1:0] burst, input int rmode, output logic [DW-1:0] first);
      int            idx, cyc, i;
      bit            err;
      logic          rdy, rr;
      logic [DW-1:0] exp;
      err = (burst != 2'b01) || (size != 3'd4);
      idx = int'((addr >> 4) % MW);
      first = '0;
      s_axi_araddr = addr; s_axi_arlen = 8'(len); s_axi_arsize = size; s_axi_arburst = burst;
      s_axi_arvalid = 1'b1;
      cyc = 0;
      do begin rdy = s_axi_arready; tick(); cyc++; end while (!rdy && cyc < 50);
      chk("ar_handshake", rdy, 1'b1);
      s_axi_arvalid = 1'b0;
      i = 0; cyc = 0;
      while (i <= len && cyc < 2000) begin
         rr = (rmode == 0) ? 1'b1 : (rmode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
         s_axi_rready = rr;
         exp = err ? '0 : mdl[(idx + i) % MW];
         chk("rvalid", s_axi_rvalid, 1'b1);
         chk("arready_busy", s_axi_arready, 1'b0);
         chk("rdata", s_axi_rdata, exp);
         chk("rlast", s_axi_rlast, (i == len));
         chk("rresp", s_axi_rresp, err ? 2'b10 : 2'b00);
         if (i == 0) first = s_axi_rdata;
         if (rr) i++;
         tick(); cyc++;
      end
      s_axi_rready = 1'b0;
      chk("r_beat_count", i, len + 1);
      chk("rvalid_after", s_axi_rvalid, 1'b0);
      chk("arready_after", s_axi_arready, 1'b1);
   endtask

   initial begin
      logic [DW-1:0] f, old_v, new_v;
      logic [AW-1:0] a;
      logic [1:0]    bt;
      logic [2:0]    sz;
      int            ln;
      s_axi_araddr = '0; s_axi_arlen = 8'd0; s_axi_arsize = 3'd0; s_axi_arburst = 2'd0;
      s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
      s_axi_awaddr = '0; s_axi_awlen = 8'd0; s_axi_awsize = 3'd0; s_axi_awburst = 2'd0;
      s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0;
      s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_arready", s_axi_arready, 1'b1);
      chk("rst_awready", s_axi_awready, 1'b1);
      chk("rst_rvalid", s_axi_rvalid, 1'b0);
      chk("rst_wready", s_axi_wready, 1'b0);
      chk("rst_bvalid", s_axi_bvalid, 1'b0);
      chk("rst_rlast", s_axi_rlast, 1'b0);
      chk("rst_rdata", s_axi_rdata, '0);
      chk("rst_rresp", s_axi_rresp, 2'b00);
      chk("rst_bresp", s_axi_bresp, 2'b00);
      rst = 1'b0;
      tick();

      for (int k = 0; k < 4; k++) axi_write(AW'(k * 32'h1000), 255, 3'd4, 2'b01, 1, '0, '1, 1'b0, 255);

      axi_write(AW'(32'h1000), 15, 3'd4, 2'b01, 0, '0, '1, 1'b0, 15);
      axi_read(AW'(32'h1000), 15, 3'd4, 2'b01, 0, f);
      chk("incr16_first", f, '0);
      axi_read(AW'(32'h1000), 15, 3'd4, 2'b01, 1, f);

      axi_write(AW'(32'h50), 0, 3'd4, 2'b01, 2, '1, '1, 1'b0, 0);
      axi_write(AW'(32'h50), 0, 3'd4, 2'b01, 2, '0, 16'h00FF, 1'b0, 0);
      axi_read(AW'(32'h50), 0, 3'd4, 2'b01, 0, f);
      chk("word5_strb", f, 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000);

      axi_read(AW'(32'h2000), 3, 3'd4, 2'b10, 0, f);
      axi_read(AW'(32'h2000), 1, 3'd3, 2'b01, 2, f);
      axi_write(AW'(32'h2000), 3, 3'd4, 2'b00, 1, '0, '1, 1'b0, 3);
      axi_write(AW'(32'h2040), 0, 3'd2, 2'b01, 1, '0, '1, 1'b0, 0);
      axi_read(AW'(32'h2000), 4, 3'd4, 2'b01, 2, f);

      axi_write(AW'(32'h3000), 3, 3'd4, 2'b01, 1, '0, '1, 1'b0, 2);
      axi_write(AW'(32'h3100), 3, 3'd4, 2'b01, 1, '0, '1, 1'b0, 99);
      axi_read(AW'(32'h3000), 3, 3'd4, 2'b01, 0, f);
      axi_read(AW'(32'h3100), 3, 3'd4, 2'b01, 0, f);
      axi_write(AW'((MW - 2) * 16), 3, 3'd4, 2'b01, 1, '0, '1, 1'b0, 3);
      axi_read(AW'((MW - 2) * 16), 3, 3'd4, 2'b01, 2, f);
      axi_read(48'hABCD_0000_3FF0, 1, 3'd4, 2'b01, 0, f);
      chk("wrap_word_last", f, mdl[MW - 1]);

      // AR and AW together on the same word; rdata keeps the pre-write value
      old_v = mdl[300];
      new_v = {$urandom, $urandom, $urandom, $urandom};
      s_axi_araddr = AW'(300 * 16); s_axi_arlen = 8'd0; s_axi_arsize = 3'd4; s_axi_arburst = 2'b01;
      s_axi_awaddr = AW'(300 * 16); s_axi_awlen = 8'd0; s_axi_awsize = 3'd4; s_axi_awburst = 2'b01;
      s_axi_arvalid = 1'b1; s_axi_awvalid = 1'b1;
      chk("conc_arready", s_axi_arready, 1'b1);
      chk("conc_awready", s_axi_awready, 1'b1);
      tick();
      s_axi_arvalid = 1'b0; s_axi_awvalid = 1'b0;
      chk("conc_rvalid", s_axi_rvalid, 1'b1);
      chk("conc_wready", s_axi_wready, 1'b1);
      s_axi_wdata = new_v; s_axi_wstrb = '1; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
      tick();
      s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
      mdl[300] = new_v;
      chk("collision_hold", s_axi_rdata, old_v);
      chk("conc_bvalid", s_axi_bvalid, 1'b1);
      chk("conc_bresp", s_axi_bresp, 2'b00);
      s_axi_bready = 1'b1; s_axi_rready = 1'b1;
      tick();
      s_axi_bready = 1'b0; s_axi_rready = 1'b0;
      chk("conc_rvalid_done", s_axi_rvalid, 1'b0);
      chk("conc_bvalid_done", s_axi_bvalid, 1'b0);
      axi_read(AW'(300 * 16), 0, 3'd4, 2'b01, 0, f);
      chk("collision_new", f, new_v);

      // Reset during beat 3 of an 8-beat read
      s_axi_araddr = AW'(100 * 16); s_axi_arlen = 8'd7; s_axi_arsize = 3'd4; s_axi_arburst = 2'b01;
      s_axi_arvalid = 1'b1;
      tick();
      s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
      repeat (3) tick();
      chk("mid_beat3_data", s_axi_rdata, mdl[103]);
      rst = 1'b1;
      #1;
      chk("mid_rst_rvalid", s_axi_rvalid, 1'b0);
      chk("mid_rst_rdata", s_axi_rdata, '0);
      chk("mid_rst_arready", s_axi_arready, 1'b1);
      tick();
      rst = 1'b0; s_axi_rready = 1'b0;
      tick();
      chk("post_rst_arready", s_axi_arready, 1'b1);
      chk("post_rst_rvalid", s_axi_rvalid, 1'b0);
      axi_read(AW'(100 * 16), 7, 3'd4, 2'b01, 0, f);

      for (int t = 0; t < 30; t++) begin
         a  = AW'({$urandom, $urandom});
         ln = $urandom_range(0, 15);
         bt = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
         sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd4;
         axi_write(a, ln, sz, bt, 1, '0, '0, 1'b1,
                   ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 15)) : ln);
         axi_read(a, ln, sz, bt, 2, f);
         axi_read(AW'({$urandom, $urandom}), int'($urandom_range(0, 7)), 3'd4, 2'b01, 2, f);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/axi_mem_slave.md
AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 48, address width; DATA_WIDTH, default 128, data width; MEM_WORDS, default 1024, backing store depth in beats (power of 2).
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
  clk  in  1  sole clock, rising edge.
  rst  in  1  asynchronous active-high reset.
  s_axi_araddr / arlen / arsize / arburst  in  ADDR_WIDTH / 8 / 3 / 2  read address channel.
  s_axi_arvalid  in  1;  s_axi_arready  out  1.
  s_axi_rdata  out  DATA_WIDTH;  s_axi_rresp  out  2;  s_axi_rlast  out  1;  s_axi_rvalid  out  1;  s_axi_rready  in  1.
  s_axi_awaddr / awlen / awsize / awburst  in  ADDR_WIDTH / 8 / 3 / 2  write address channel.
  s_axi_awvalid  in  1;  s_axi_awready  out  1.
  s_axi_wdata  in  DATA_WIDTH;  s_axi_wstrb  in  DATA_WIDTH/8;  s_axi_wlast  in  1;  s_axi_wvalid  in  1;  s_axi_wready  out  1.
  s_axi_bresp  out  2;  s_axi_bvalid  out  1;  s_axi_bready  in  1.

Function
REQ-003 SHALL act as AXI4 responder to one initiator; read and write paths are independent FSMs, one outstanding transaction each.
REQ-004 SHALL index words as idx = (addr >> log2(DATA_WIDTH/8)) mod MEM_WORDS; the per-beat increment wraps at MEM_WORDS.
REQ-005 Read FSM SHALL have states R_IDLE (arready=1) and R_DATA (arready=0, rvalid=1).
REQ-006 On an AR handshake in cycle N, the block SHALL latch idx, arlen, and error status and assert rvalid in cycle N+1 with rdata = mem[idx].
REQ-007 rdata, rresp, and rlast SHALL hold stable while rvalid=1 and rready=0.
REQ-008 On each R handshake, the block SHALL advance idx and load the next word into rdata in the same edge; no bubble between beats.
REQ-009 rlast SHALL be 1 exactly on beat arlen (0-based); after the last handshake, the block SHALL return to R_IDLE, so arready=1 in the next cycle.
REQ-010 Write FSM SHALL have states W_IDLE (awready=1), W_DATA (wready=1), and W_RESP (bvalid=1); all other ready/valid signals are 0 in each state.
REQ-011 In W_DATA, each W handshake SHALL write mem[idx] byte lanes where wstrb=1 and leave other lanes unchanged, then advance idx.
REQ-012 The burst length SHALL be awlen+1 beats regardless of wlast; after beat awlen, the block SHALL enter W_RESP.
REQ-013 In W_RESP, bvalid SHALL hold until bready; then the block SHALL return to W_IDLE.
REQ-014 A burst SHALL be flagged as error if burst type != INCR (2'b01) or size != log2(DATA_WIDTH/8).
REQ-015 Error reads SHALL return rdata=0 with rresp=SLVERR (2'b10) on every beat.
REQ-016 Error writes SHALL be discarded and return bresp=SLVERR.
REQ-017 A write SHALL also report SLVERR if wlast is 0 on beat awlen or 1 on any earlier beat; data of that burst is still written.
REQ-018 Otherwise, rresp and bresp SHALL be OKAY (2'b00).
REQ-019 Same-word collision: if a W beat writes the word currently loaded in rdata, the block SHALL keep the pre-write value in rdata; the next read of that word SHALL return the new value.
REQ-020 AR and AW accepted in the same cycle SHALL both proceed concurrently; there SHALL be no ordering between the channels.
REQ-021 arlen=0 and awlen=0 SHALL produce single-beat transfers with rlast=1 and a single W beat expected.

Reset
REQ-022 While rst=1, the block SHALL force: arready=1, awready=1, rvalid=0, wready=0, bvalid=0, rlast=0, rdata=0, rresp=0, bresp=0, and both FSMs to IDLE.
REQ-023 Reset asserted mid-burst SHALL abort both transactions with no response issued; memory contents SHALL NOT be reset.

Verification
REQ-024 Write a 16-beat INCR burst at 0x1000 (wdata=beat index, wstrb all ones), then read the same burst -> bresp=OKAY; 16 R beats with data 0..15, rlast only on beat 15, rresp=OKAY.
REQ-025 Read with rready toggling 1/0 every cycle -> rdata and rlast stable during stalls; no lost or duplicated beats.
REQ-026 Write 0xFF.. to word 5, then 1 beat with wstrb=16'h00FF and wdata=0 -> readback of word 5 = upper 8 bytes 0xFF, lower 8 bytes 0x00.
REQ-027 AR with arburst=2'b10 and arlen=3 -> 4 beats of rdata=0 and rresp=2'b10; AW with awburst=FIXED -> bresp=2'b10 and memory unchanged.
REQ-028 4-beat write with wlast on beat 2 -> 4 beats accepted and bresp=SLVERR; a burst starting at word MEM_WORDS-2 with len 3 -> words MEM_WORDS-2, MEM_WORDS-1, 0, 1 written.
REQ-029 Assert rst during R beat 3 of 8 -> rvalid=0 immediately, arready=1 after release, and a new AR is served normally.
